// File: rtl/fetch_stage.sv
// IF stage of the RV32I pipeline: PC register, one-outstanding instruction-memory
// handshake, response parking buffer and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  ifid_t       ifid_q, ifid_d;

  logic        avail;
  logic        deliver;
  logic [31:0] avail_instr;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = PCTargetE & 32'hFFFF_FFFC;

  // An instruction is available either straight from memory or from the park buffer.
  assign avail       = ((state_q == S_WAIT) && imem_valid) || (state_q == S_HOLD);
  assign avail_instr = (state_q == S_HOLD) ? buf_q : imem_rdata;
  assign deliver     = avail && !StallF && !StallD && !PCSrcE;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;

    unique case (state_q)
      S_IDLE:  state_d = S_ISSUE;
      S_ISSUE: begin
        if (!PCSrcE && imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (PCSrcE) begin
          state_d = imem_valid ? S_ISSUE : S_DRAIN;
        end else if (deliver) begin
          state_d = S_ISSUE;
        end else if (imem_valid) begin
          state_d = S_HOLD;
          buf_d   = imem_rdata;
        end
      end
      S_HOLD: begin
        if (PCSrcE || deliver) state_d = S_ISSUE;
      end
      S_DRAIN: begin
        if (imem_valid) state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect outranks sequential advance; PC only moves forward on a delivery.
    if (PCSrcE) begin
      pc_d = redirect_pc;
    end else if (deliver) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    ifid_d = ifid_q;
    if (FlushD) begin
      ifid_d = IFID_BUBBLE;
    end else if (StallD) begin
      ifid_d = ifid_q;
    end else if (deliver) begin
      ifid_d = '{instr: avail_instr, pc: pc_q, pc_plus4: pc_plus4, valid: 1'b1};
    end else begin
      ifid_d = IFID_BUBBLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      buf_q   <= 32'h0;
      ifid_q  <= IFID_BUBBLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      ifid_q  <= ifid_d;
    end
  end

  assign imem_req  = (state_q == S_ISSUE);
  assign imem_addr = pc_q;
  assign PCF       = pc_q;
  assign InstrD    = ifid_q.instr;
  assign PCD       = ifid_q.pc;
  assign PCPlus4D  = ifid_q.pc_plus4;
  assign ValidD    = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID deliveries into a
// scoreboard queue, and an independent monitor pops them whenever decode loads a real instruction.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_valid(imem_valid),
    .imem_rdata(imem_rdata),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after each rising edge; the monitor samples at +1.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: a valid IF/ID entry loaded on an edge without StallD is a new delivery.
  always @(posedge clk) begin
    #1;
    if (!rst && ValidD && !StallD) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_delivery: got instr %h pc %h expected none", InstrD, PCD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_instr", InstrD, e.instr);
        check("sb_pcd", PCD, e.pc);
        check("sb_pcplus4", PCPlus4D, e.pc_plus4);
      end
    end
  end

  // Starts in ISSUE for addr; memory accepts after ready_wait cycles and answers the next cycle.
  task automatic mem_fetch(input logic [31:0] addr, input logic [31:0] instr,
                           input logic [31:0] next_pc, input int ready_wait);
    check("issue_req", {31'b0, imem_req}, 32'd1);
    check("issue_addr", imem_addr, addr);
    imem_ready = 1'b0;
    for (int i = 0; i < ready_wait; i++) begin
      step();
      check("bp_req", {31'b0, imem_req}, 32'd1);
      check("bp_addr", imem_addr, addr);
      check("bp_validd", {31'b0, ValidD}, 32'd0);
      check("bp_instrd", InstrD, NOP);
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    check("wait_req", {31'b0, imem_req}, 32'd0);
    check("wait_bubble", {31'b0, ValidD}, 32'd0);
    imem_valid = 1'b1;
    imem_rdata = instr;
    exp_q.push_back('{instr: instr, pc: addr, pc_plus4: next_pc});
    step();
    imem_valid = 1'b0;
    check("next_pcf", PCF, next_pc);
    check("next_req", {31'b0, imem_req}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'h0;
    imem_ready = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0;

    // Reset values while rst is held, even with memory inputs wiggling.
    imem_ready = 1'b1; imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    repeat (3) step();
    check("rst_pcf", PCF, RST_PC);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_instrd", InstrD, NOP);
    check("rst_pcd", PCD, 32'h0);
    check("rst_pcplus4d", PCPlus4D, 32'h0);
    check("rst_validd", {31'b0, ValidD}, 32'd0);
    imem_ready = 1'b0; imem_valid = 1'b0;

    // Boot: IDLE for one cycle, then back-to-back best-case fetches.
    rst = 1'b0;
    check("idle_req", {31'b0, imem_req}, 32'd0);
    step();
    mem_fetch(32'h0000_1000, 32'h0010_0093, 32'h0000_1004, 0);
    mem_fetch(32'h0000_1004, 32'h0020_0113, 32'h0000_1008, 0);
    mem_fetch(32'h0000_1008, 32'h0030_0193, 32'h0000_100C, 0);

    // Memory backpressure for three cycles.
    mem_fetch(32'h0000_100C, 32'h0040_0213, 32'h0000_1010, 3);

    // StallD alone holds IF/ID; FlushD together with StallD bubbles it.
    StallD = 1'b1;
    step();
    check("stalld_instr", InstrD, 32'h0040_0213);
    check("stalld_pcd", PCD, 32'h0000_100C);
    check("stalld_valid", {31'b0, ValidD}, 32'd1);
    FlushD = 1'b1;
    step();
    FlushD = 1'b0; StallD = 1'b0;
    check("flush_instr", InstrD, NOP);
    check("flush_pcd", PCD, 32'h0);
    check("flush_valid", {31'b0, ValidD}, 32'd0);
    check("flush_pcf", PCF, 32'h0000_1010);

    // Decode stall while the response arrives: parked in HOLD, delivered on release.
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    StallF = 1'b1; StallD = 1'b1;
    imem_valid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_valid = 1'b0; imem_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      check("hold_instr", InstrD, NOP);
      check("hold_valid", {31'b0, ValidD}, 32'd0);
      check("hold_pcf", PCF, 32'h0000_1010);
      check("hold_req", {31'b0, imem_req}, 32'd0);
      if (i == 0) step();
    end
    StallF = 1'b0; StallD = 1'b0;
    exp_q.push_back('{instr: 32'h0050_0093, pc: 32'h0000_1010, pc_plus4: 32'h0000_1014});
    step();
    check("rel_pcf", PCF, 32'h0000_1014);
    check("rel_req", {31'b0, imem_req}, 32'd1);

    // Redirect while waiting: DRAIN discards the late response, then fetch the target.
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    PCSrcE = 1'b1; PCTargetE = 32'h0000_2002; FlushD = 1'b1;
    step();
    PCSrcE = 1'b0; FlushD = 1'b0;
    check("drain_pcf", PCF, 32'h0000_2000);
    check("drain_req", {31'b0, imem_req}, 32'd0);
    step();
    check("drain_stay_req", {31'b0, imem_req}, 32'd0);
    imem_valid = 1'b1; imem_rdata = 32'hBAD0_0001;
    step();
    imem_valid = 1'b0;
    check("drain_done_valid", {31'b0, ValidD}, 32'd0);
    check("drain_done_instr", InstrD, NOP);
    mem_fetch(32'h0000_2000, 32'h0060_0293, 32'h0000_2004, 0);

    // Redirect in the same cycle as the response, with FlushD and StallD.
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_valid = 1'b1; imem_rdata = 32'hBAD0_0002;
    PCSrcE = 1'b1; PCTargetE = 32'h0000_3000; FlushD = 1'b1; StallD = 1'b1;
    step();
    imem_valid = 1'b0; PCSrcE = 1'b0; FlushD = 1'b0; StallD = 1'b0;
    check("coin_req", {31'b0, imem_req}, 32'd1);
    check("coin_addr", imem_addr, 32'h0000_3000);
    check("coin_instr", InstrD, NOP);
    check("coin_valid", {31'b0, ValidD}, 32'd0);
    mem_fetch(32'h0000_3000, 32'h0070_0313, 32'h0000_3004, 0);

    // Redirect from ISSUE with a misaligned target, then PC wrap on delivery.
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
    step();
    PCSrcE = 1'b0;
    check("redir_issue_pcf", PCF, 32'hFFFF_FFFC);
    mem_fetch(32'hFFFF_FFFC, 32'h0080_0393, 32'h0000_0000, 0);

    // Reset mid-flight: IF/ID held valid by StallD, then rst in WAIT clears everything at once.
    StallD = 1'b1; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    check("pre_rst_req", {31'b0, imem_req}, 32'd0);
    check("pre_rst_valid", {31'b0, ValidD}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_pcf", PCF, RST_PC);
    check("arst_addr", imem_addr, RST_PC);
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_instr", InstrD, NOP);
    check("arst_pcd", PCD, 32'h0);
    check("arst_pcplus4d", PCPlus4D, 32'h0);
    check("arst_valid", {31'b0, ValidD}, 32'd0);
    step();
    StallD = 1'b0;
    rst = 1'b0;
    imem_valid = 1'b1; imem_rdata = 32'hBAD0_0003;
    step();
    check("late_req", {31'b0, imem_req}, 32'd1);
    check("late_addr", imem_addr, RST_PC);
    check("late_valid", {31'b0, ValidD}, 32'd0);
    step();
    imem_valid = 1'b0;
    check("late_issue_req", {31'b0, imem_req}, 32'd1);
    check("late_issue_pcf", PCF, RST_PC);
    check("late_issue_valid", {31'b0, ValidD}, 32'd0);
    mem_fetch(32'h0000_1000, 32'h0090_0413, 32'h0000_1004, 0);

    repeat (2) step();
    check("sb_pending", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

IF stage of the pipelined RV32I core: owns the PC register, runs a one-outstanding request/response handshake with instruction memory, and drives the IF/ID pipeline register into decode. It consumes the hazard unit's StallF/StallD/FlushD and the EX-stage redirect (PCSrcE, PCTargetE). It inserts NOP bubbles into decode whenever memory latency leaves it with no instruction to deliver.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- StallF  in  1  hazard unit: hold PC
- StallD  in  1  hazard unit: hold IF/ID
- FlushD  in  1  hazard unit: bubble IF/ID
- PCSrcE  in  1  redirect taken in EX
- PCTargetE  in  32  redirect target
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (= PCF)
- imem_ready  in  1  memory accepts request this cycle
- imem_valid  in  1  response valid
- imem_rdata  in  32  response instruction
- PCF  out  32  current fetch PC
- InstrD  out  32  IF/ID instruction
- PCD  out  32  IF/ID PC
- PCPlus4D  out  32  IF/ID PC+4
- ValidD  out  1  IF/ID holds a real instruction

## Operation
- FSM states: IDLE, ISSUE, WAIT, HOLD, DRAIN.
- IDLE: entered only on reset; goes to ISSUE next cycle.
- ISSUE: imem_req=1 and imem_addr=PCF. Handshake accepted when imem_req && imem_ready; goes to WAIT. Otherwise stays in ISSUE.
- WAIT: one request outstanding. On imem_valid, the response is "available".
- HOLD: a response is parked in an internal 32-bit buffer because decode was stalled.
- DRAIN: the outstanding response belongs to a squashed path. Discard it on imem_valid, then go to ISSUE.
- deliver = response available (WAIT&&imem_valid, or HOLD) && !StallF && !StallD && !PCSrcE.
  - On deliver: IF/ID ← {instr, PCF, PCF+4, ValidD=1}; PCF ← PCF+4; go to ISSUE.
- WAIT&&imem_valid without deliver, and no redirect: buffer instr; go to HOLD. PCF is unchanged.
- Redirect (PCSrcE=1), which has priority over all stalls and deliveries:
  - PCF ← {PCTargetE[31:2],2'b00}.
  - From ISSUE (accepted or not), HOLD, or WAIT with imem_valid=1: go to ISSUE. The buffer or response is dropped.
  - From WAIT with imem_valid=0: go to DRAIN.
  - From DRAIN: stay in DRAIN. If imem_valid=1 in that same cycle, go to ISSUE.
- IF/ID register priority: FlushD > StallD > deliver > bubble.
  - Flush and bubble both load {NOP_INSTR, PCD/PCPlus4D=0, ValidD=0}.
  - Bubble is inserted whenever !StallD and there is no deliver.
  - StallD holds all IF/ID fields.
- Arithmetic: PCF+4 is 32-bit and wraps (32'hFFFF_FFFC+4 = 0). Redirect target bits [1:0] are forced to 0.
- imem_valid outside WAIT/DRAIN is ignored (protocol error; no state change).

## Timing
- Reset values: state=IDLE, PCF=RESET_PC, imem_req=0, imem_addr=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, buffer=0.
- A reset asserted mid-transaction returns to IDLE immediately. Any in-flight memory response after reset release arrives in IDLE/ISSUE and is ignored.
- First imem_req is asserted the 2nd cycle after reset deasserts (IDLE → ISSUE).
- Best case (imem_ready=1, imem_valid 1 cycle after acceptance): an instruction appears in IF/ID 2 cycles after its request. Steady throughput is 1 instruction per 2 cycles, with a bubble in each alternate cycle.
- Redirect latency: imem_req for the target is asserted the cycle after PCSrcE when no drain is needed. Otherwise it is asserted the cycle after the squashed imem_valid.
- All outputs except imem_req/imem_addr are registered. imem_req and imem_addr are decoded from the state and PCF registers only, with no input-to-output combinational path.

## Test plan
- Reset/boot: RESET_PC=32'h0000_1000; release rst with a 1-cycle-latency memory → imem_addr sequence 0x1000, 0x1004, 0x1008. InstrD carries those words with ValidD=1 and a NOP bubble (ValidD=0) in between. All outputs equal reset values while rst=1.
- Memory backpressure: imem_ready=0 for 3 cycles in ISSUE → imem_req and imem_addr are held stable; the request is accepted on the 4th cycle. IF/ID holds NOP with ValidD=0 meanwhile.
- Decode stall: StallF=StallD=1 for 2 cycles while imem_valid arrives with 0x00500093 → FSM enters HOLD and IF/ID is unchanged. On release, InstrD=0x00500093, PCD=PCF, and PCF advances by 4.
- Redirect while waiting: PCSrcE=1 with PCTargetE=0x2002 in WAIT, with imem_valid 2 cycles later → DRAIN. The response is discarded, never reaching InstrD. The next imem_addr is 0x2000, and IF/ID is flushed to NOP with ValidD=0.
- Redirect coinciding with response: PCSrcE=1 and imem_valid=1 in the same cycle → the instruction is dropped and the next cycle issues the target. FlushD=1 together with StallD=1 → IF/ID becomes a NOP.
- PC wrap and reset mid-flight: PCF=0xFFFFFFFC delivered → next PCF is 0x00000000. Asserting rst in WAIT → immediate return to reset values, with a late imem_valid ignored.
